// File: rtl/layer3_pixel_buffer_pkg.sv
// Shared constants, types and address helpers for the layer-3 pixel frame buffer.
// Holds the frame geometry and word widths used by the buffer, its SRAM and the bench.
package layer3_pixel_buffer_pkg;

   localparam int LAYER3_WIDTH               = 28;
   localparam int LAYER3_WEIGHT_INPUT_LENGTH = 128;
   localparam int WORDLENGTH                 = 16;

   localparam int PIXEL_COUNT = LAYER3_WIDTH * LAYER3_WIDTH;
   localparam int ADDR_W      = $clog2(PIXEL_COUNT);
   localparam int COUNT_W     = $clog2(PIXEL_COUNT + 1);

   typedef logic [LAYER3_WEIGHT_INPUT_LENGTH-1:0] pixel_t;
   typedef logic [WORDLENGTH-1:0]                 coord_t;
   typedef logic [ADDR_W-1:0]                     addr_t;

   function automatic logic coord_in_range(input coord_t row, input coord_t col);
      return (row < coord_t'(LAYER3_WIDTH)) && (col < coord_t'(LAYER3_WIDTH));
   endfunction

   // Only meaningful when coord_in_range() holds; callers gate on that.
   function automatic addr_t pixel_index(input coord_t row, input coord_t col);
      return addr_t'(row * coord_t'(LAYER3_WIDTH) + col);
   endfunction

endpackage

// File: rtl/layer3_pixel_buffer_if.sv
// Write/read/release bus between the conv layer, the pixel buffer and maxpooling.
// The master modport is the producer/consumer side; the slave modport is the buffer itself.
interface layer3_pixel_buffer_if;
   import layer3_pixel_buffer_pkg::*;

   logic   save_enable;
   coord_t save_row;
   coord_t save_col;
   pixel_t save_data;
   logic   read_pixel_signal;
   coord_t read_row_addr;
   coord_t read_col_addr;
   logic   layer3_calculation_done;
   logic   pixel_store_done;
   pixel_t output_data;
   logic   buffer_ready;

   modport master (
      output save_enable, save_row, save_col, save_data,
      output read_pixel_signal, read_row_addr, read_col_addr,
      output layer3_calculation_done,
      input  pixel_store_done, output_data, buffer_ready
   );

   modport slave (
      input  save_enable, save_row, save_col, save_data,
      input  read_pixel_signal, read_row_addr, read_col_addr,
      input  layer3_calculation_done,
      output pixel_store_done, output_data, buffer_ready
   );

endinterface

// File: rtl/layer3_pixel_buffer_sram.sv
// 28x28 frame store: one write port and one registered read port of 128-bit words.
// Reads are read-before-write and an out-of-range read loads zero into the output register.
module pixel_sram_28x28
   import layer3_pixel_buffer_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   wr_en,
   input  addr_t  wr_addr,
   input  pixel_t wr_data,
   input  logic   rd_en,
   input  logic   rd_hit,
   input  addr_t  rd_addr,
   output pixel_t rd_data
);

   pixel_t mem [PIXEL_COUNT];
   pixel_t rd_data_reg;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Holding the register when rd_en is low keeps the last pixel on the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_reg <= '0;
      end else if (rd_en) begin
         rd_data_reg <= rd_hit ? mem[rd_addr] : '0;
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/layer3_pixel_buffer.sv
// Layer-3 frame buffer: fills a 28x28 frame, pulses when complete, then locks it for
// reading until the consumer releases it; reads are served in every state.
module layer3_pixel_buffer
   import layer3_pixel_buffer_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   layer3_pixel_buffer_if.slave bus
);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      DONE  = 2'd1,
      READY = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [COUNT_W-1:0] store_count_reg, store_count_next;

   logic   write_hit;
   logic   write_accept;
   logic   read_hit;
   addr_t  write_addr;
   addr_t  read_addr;
   pixel_t read_data;

   assign write_hit    = coord_in_range(bus.save_row, bus.save_col);
   assign read_hit     = coord_in_range(bus.read_row_addr, bus.read_col_addr);
   assign write_addr   = pixel_index(bus.save_row, bus.save_col);
   assign read_addr    = pixel_index(bus.read_row_addr, bus.read_col_addr);
   assign write_accept = (state_reg == FILL) && bus.save_enable && write_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= FILL;
         store_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         store_count_reg <= store_count_next;
      end
   end

   // The counter only moves on accepted writes and is cleared when the frame is released.
   always_comb begin
      state_next       = state_reg;
      store_count_next = store_count_reg;
      case (state_reg)
         FILL: begin
            if (write_accept) begin
               store_count_next = store_count_reg + COUNT_W'(1);
               if (store_count_next == COUNT_W'(PIXEL_COUNT)) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = READY;
         end
         READY: begin
            if (bus.layer3_calculation_done) begin
               state_next       = FILL;
               store_count_next = '0;
            end
         end
         default: begin
            state_next       = FILL;
            store_count_next = '0;
         end
      endcase
   end

   assign bus.pixel_store_done = (state_reg == DONE);
   assign bus.buffer_ready     = (state_reg == READY);

   pixel_sram_28x28 u_sram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (write_accept),
      .wr_addr (write_addr),
      .wr_data (bus.save_data),
      .rd_en   (bus.read_pixel_signal),
      .rd_hit  (read_hit),
      .rd_addr (read_addr),
      .rd_data (read_data)
   );

   assign bus.output_data = read_data;

endmodule

// File: tb/tb_layer3_pixel_buffer.sv
// Randomised bench for layer3_pixel_buffer, checked cycle by cycle against a
// frame-level reference model (pixel array, accepted-write count, lock flag).
module tb_layer3_pixel_buffer;
   import layer3_pixel_buffer_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   layer3_pixel_buffer_if bus ();

   layer3_pixel_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model state
   pixel_t ref_mem   [PIXEL_COUNT];
   bit     ref_known [PIXEL_COUNT];
   int     ref_stored;
   bit     ref_pulse;
   bit     ref_locked;
   pixel_t ref_out;
   bit     ref_out_known;

   int tests_run    = 0;
   int tests_failed = 0;
   int pulses       = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic pixel_t raster_pixel(input int idx);
      logic [15:0] w;
      w = 16'(idx);
      return {8{w}};
   endfunction

   function automatic bit in_frame(input int r, input int c);
      return (r < LAYER3_WIDTH) && (c < LAYER3_WIDTH);
   endfunction

   task automatic model_reset();
      ref_stored    = 0;
      ref_pulse     = 0;
      ref_locked    = 0;
      ref_out       = '0;
      ref_out_known = 1;
      for (int i = 0; i < PIXEL_COUNT; i++) ref_known[i] = 0;
   endtask

   // One clock cycle: drive inputs, advance the model at the edge, compare just after it.
   task automatic cycle(input bit we, input int wr, input int wc, input pixel_t wd,
                        input bit re, input int rr, input int rc, input bit cd);
      bit accept;
      bus.save_enable             = we;
      bus.save_row                = 16'(wr);
      bus.save_col                = 16'(wc);
      bus.save_data               = wd;
      bus.read_pixel_signal       = re;
      bus.read_row_addr           = 16'(rr);
      bus.read_col_addr           = 16'(rc);
      bus.layer3_calculation_done = cd;
      @(posedge clk);
      if (re) begin
         if (in_frame(rr, rc)) begin
            ref_out       = ref_mem[rr * LAYER3_WIDTH + rc];
            ref_out_known = ref_known[rr * LAYER3_WIDTH + rc];
         end else begin
            ref_out       = '0;
            ref_out_known = 1;
         end
      end
      accept = we && in_frame(wr, wc) && !ref_locked && !ref_pulse;
      if (ref_pulse) begin
         ref_pulse  = 0;
         ref_locked = 1;
      end else if (ref_locked) begin
         if (cd) begin
            ref_locked = 0;
            ref_stored = 0;
         end
      end else if (accept) begin
         ref_mem[wr * LAYER3_WIDTH + wc]   = wd;
         ref_known[wr * LAYER3_WIDTH + wc] = 1;
         ref_stored++;
         if (ref_stored == PIXEL_COUNT) ref_pulse = 1;
      end
      #1;
      check("pixel_store_done", 128'(bus.pixel_store_done), 128'(ref_pulse));
      check("buffer_ready", 128'(bus.buffer_ready), 128'(ref_locked));
      if (ref_out_known) check("output_data", bus.output_data, ref_out);
      if (bus.pixel_store_done) pulses++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, 0, 0, 0);
   endtask

   // Writes `target` accepted pixels (raster order or random positions) with random
   // noise: invalid addresses, disabled strobes, ignored releases, random reads.
   task automatic fill_frame(input bit raster, input int target);
      int     n;
      int     r, c, rr, rc, kind;
      bit     re;
      pixel_t d;
      n = 0;
      while (n < target) begin
         kind = $urandom_range(9);
         if (raster) begin
            r = n / LAYER3_WIDTH;
            c = n % LAYER3_WIDTH;
            d = raster_pixel(n);
         end else begin
            r = $urandom_range(LAYER3_WIDTH - 1);
            c = $urandom_range(LAYER3_WIDTH - 1);
            d = {$urandom, $urandom, $urandom, $urandom};
         end
         re = 1'($urandom_range(1));
         if ($urandom_range(3) == 0) begin
            rr = r;
            rc = c;
         end else begin
            rr = $urandom_range(31);
            rc = $urandom_range(31);
         end
         if (kind == 0) begin
            cycle(1, LAYER3_WIDTH + $urandom_range(4), $urandom_range(27), d, re, rr, rc, 0);
         end else if (kind == 1) begin
            cycle(1, $urandom_range(27), 30, d, re, rr, rc, 1);
         end else if (kind == 2) begin
            cycle(0, r, c, d, re, rr, rc, 0);
         end else begin
            cycle(1, r, c, d, re, rr, rc, 1'($urandom_range(3) == 0));
            n++;
         end
      end
   endtask

   task automatic release_frame();
      cycle(0, 0, 0, '0, 0, 0, 0, 1);
      check("release_to_fill", 128'(bus.buffer_ready), 128'(0));
   endtask

   initial begin
      rst = 1'b1;
      bus.save_enable             = 0;
      bus.save_row                = '0;
      bus.save_col                = '0;
      bus.save_data               = '0;
      bus.read_pixel_signal       = 0;
      bus.read_row_addr           = '0;
      bus.read_col_addr           = '0;
      bus.layer3_calculation_done = 0;
      model_reset();
      #1;
      check("reset_store_done", 128'(bus.pixel_store_done), 128'(0));
      check("reset_ready", 128'(bus.buffer_ready), 128'(0));
      check("reset_output", bus.output_data, 128'(0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Frame 1: raster data {8{row*28+col}}
      pulses = 0;
      fill_frame(1, PIXEL_COUNT);
      idle(2);
      check("frame1_pulses", 128'(pulses), 128'(1));
      check("frame1_ready", 128'(bus.buffer_ready), 128'(1));
      $display("[TB] frame 1 raster stored, buffer locked");

      // Locked frame: known pixel, ignored write, out-of-range read
      cycle(0, 0, 0, '0, 1, 5, 7, 0);
      check("read_5_7", bus.output_data, {8{16'd147}});
      cycle(1, 5, 7, {4{32'hDEADBEEF}}, 0, 0, 0, 0);
      check("hold_output", bus.output_data, {8{16'd147}});
      cycle(0, 0, 0, '0, 1, 5, 7, 0);
      check("locked_5_7", bus.output_data, {8{16'd147}});
      cycle(0, 0, 0, '0, 1, 28, 0, 0);
      check("read_28_0", bus.output_data, 128'(0));
      for (int i = 0; i < 40; i++) begin
         cycle(1, $urandom_range(27), $urandom_range(27), {$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(1)), $urandom_range(31), $urandom_range(31), 0);
      end
      $display("[TB] locked-frame reads and ignored writes done");

      // Maxpooling-style stream: 784 back-to-back raster reads
      for (int i = 0; i < PIXEL_COUNT; i++) begin
         cycle(0, 0, 0, '0, 1, i / LAYER3_WIDTH, i % LAYER3_WIDTH, 0);
         check("stream", bus.output_data, raster_pixel(i));
      end
      $display("[TB] raster read stream done");

      // Frame 2: random positions after release
      release_frame();
      pulses = 0;
      fill_frame(0, PIXEL_COUNT);
      idle(2);
      check("frame2_pulses", 128'(pulses), 128'(1));
      for (int i = 0; i < 100; i++) begin
         cycle(0, 0, 0, '0, 1, $urandom_range(27), $urandom_range(27), 0);
      end
      $display("[TB] frame 2 random fill stored and sampled");

      // Reset after 400 writes of frame 3
      release_frame();
      pulses = 0;
      fill_frame(1, 400);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("midreset_store_done", 128'(bus.pixel_store_done), 128'(0));
      check("midreset_ready", 128'(bus.buffer_ready), 128'(0));
      check("midreset_output", bus.output_data, 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      check("after_reset_output", bus.output_data, 128'(0));
      fill_frame(1, PIXEL_COUNT - 1);
      idle(3);
      check("partial_no_pulse", 128'(pulses), 128'(0));
      cycle(1, LAYER3_WIDTH - 1, LAYER3_WIDTH - 1, raster_pixel(PIXEL_COUNT - 1), 0, 0, 0, 0);
      idle(2);
      check("frame3_pulses", 128'(pulses), 128'(1));
      $display("[TB] mid-fill reset and fresh frame done");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/layer3_pixel_buffer.md
LAYER3_PIXEL_BUFFER -- requirements
Module: layer3_pixel_buffer

Interface
REQ-001 Params (`def.svh`): `LAYER3_WIDTH` = 28, pixels per row/col; `LAYER3_WEIGHT_INPUT_LENGTH` = 128, 8 channels x 16 bit; `WORDLENGTH` = 16, address word.
REQ-002 clk  input  1  single clock; all state on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 save_enable  input  1  write strobe from upstream conv layer.
REQ-005 save_row  input  WORDLENGTH  write row address.
REQ-006 save_col  input  WORDLENGTH  write column address.
REQ-007 save_data  input  128  pixel to store, all 8 channels.
REQ-008 read_pixel_signal  input  1  read request from maxpooling.
REQ-009 read_row_addr  input  WORDLENGTH  read row.
REQ-010 read_col_addr  input  WORDLENGTH  read column.
REQ-011 layer3_calculation_done  input  1  consumer finished frame; releases buffer.
REQ-012 pixel_store_done  output  1  one-cycle pulse: full frame stored.
REQ-013 output_data  output  128  read data, feeds maxpooling input_data.
REQ-014 buffer_ready  output  1  high while the frame is locked for reading.

Function
REQ-015 Storage SHALL be `LAYER3_WIDTH` x `LAYER3_WIDTH` words of 128 bits; index = row*28 + col.
REQ-016 FSM states SHALL be FILL (after reset), DONE, READY.
REQ-017 FILL: a write with save_enable=1, row<28 and col<28 SHALL store save_data and increment the 10-bit store counter.
REQ-018 Writes with row>=28 or col>=28 SHALL be ignored and not counted.
REQ-019 FILL->DONE when the counter reaches 784 after an accepted write.
REQ-020 DONE SHALL last exactly one cycle with pixel_store_done=1, then go to READY.
REQ-021 READY: buffer_ready=1; all writes SHALL be ignored (frame locked).
REQ-022 READY->FILL on layer3_calculation_done=1; the store counter SHALL clear on the same edge.
REQ-023 layer3_calculation_done in FILL or DONE SHALL be ignored.
REQ-024 Read latency SHALL be exactly 1 cycle: address sampled at edge N, data valid on output_data after edge N until edge N+1.
REQ-025 Reads SHALL be allowed in every state, back-to-back, one per cycle.
REQ-026 read_pixel_signal=0 SHALL hold output_data at its previous value.
REQ-027 An out-of-range read address SHALL return 128'd0.
REQ-028 Same-cycle write and read to one address in FILL SHALL return the old data (read-before-write).
REQ-029 Memory contents SHALL persist across READY->FILL; only the counter clears.

Reset
REQ-030 rst=1 SHALL force state=FILL, counter=0, pixel_store_done=0, buffer_ready=0, output_data=0, immediately and asynchronously.
REQ-031 Reset mid-fill SHALL discard the fill progress; memory contents are not cleared and are undefined to the consumer.

Structure
REQ-032 Width and length constants SHALL come from `def.svh`; there SHALL be no local magic numbers for 28, 784 or 128.
REQ-033 FSM state encoding SHALL be a localparam set inside the module.
REQ-034 Storage SHALL be a single sub-module `pixel_sram_28x28`: 1 write port, 1 registered read port, 128-bit words.
REQ-035 The store counter SHALL be a separate 10-bit register, not `counter_cnn`; it needs a conditional increment.

Verification
REQ-036 Raster write of 784 pixels, data = {8{row*28+col}} -> pixel_store_done pulses once, on the cycle after the write to (27,27); buffer_ready=1 on the next cycle.
REQ-037 In READY, read (5,7) at edge N -> output_data = {8{16'd147}} after edge N; a write to (5,7) in READY leaves the value unchanged.
REQ-038 Write (28,0) and (0,30) during FILL -> counter unchanged; a read of (28,0) returns 0.
REQ-039 Pulse layer3_calculation_done in READY -> FILL next cycle, counter=0; a second full frame produces a second pixel_store_done.
REQ-040 Assert rst after 400 writes -> all outputs 0 at once; 784 fresh writes are required before pixel_store_done.
REQ-041 Maxpooling-style stream of 784 consecutive reads in READY -> output_data sequence matches the raster order with exactly 1-cycle lag.
